alu: RTL and testbench



---
 rtl/alu.sv | 98 +++++++++
 tb/tb_alu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered 64-bit RV64IM ALU: one-cycle latency, one operation accepted per cycle.
// Define ALU_MULDIV_EN to build the MUL/MULH/DIV/REM datapath; otherwise ops 7-10 return 0.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [3:0]  op,
  input  logic        valid_in,
  output logic [63:0] result,
  output logic        is_equal,
  output logic        valid_out
);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpMul  = 4'd7;
  localparam logic [3:0] OpMulh = 4'd8;
  localparam logic [3:0] OpDiv  = 4'd9;
  localparam logic [3:0] OpRem  = 4'd10;
  localparam logic [3:0] OpSlt  = 4'd11;

  localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;

  logic [63:0] res_d;
  logic [63:0] mul_lo, mul_hi, div_q, rem_r;

`ifdef ALU_MULDIV_EN
  logic signed [127:0] prod;
  logic signed [63:0]  sa, sb;

  assign sa     = $signed(a);
  assign sb     = $signed(b);
  assign prod   = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
  assign mul_lo = prod[63:0];
  assign mul_hi = prod[127:64];

  // Zero divisor and MIN/-1 are resolved here so the divider never sees them.
  always_comb begin
    div_q = '1;
    rem_r = a;
    if (b == '0) begin
      div_q = '1;
      rem_r = a;
    end else if ((a == MinNeg) && (b == '1)) begin
      div_q = a;
      rem_r = '0;
    end else begin
      div_q = $unsigned(sa / sb);
      rem_r = $unsigned(sa % sb);
    end
  end
`else
  assign mul_lo = '0;
  assign mul_hi = '0;
  assign div_q  = '0;
  assign rem_r  = '0;
`endif

  always_comb begin
    res_d = '0;
    case (op)
      OpAdd:   res_d = a + b;
      OpSub:   res_d = a - b;
      OpAnd:   res_d = a & b;
      OpOr:    res_d = a | b;
      OpXor:   res_d = a ^ b;
      OpSll:   res_d = a << b[5:0];
      OpSrl:   res_d = a >> b[5:0];
      OpMul:   res_d = mul_lo;
      OpMulh:  res_d = mul_hi;
      OpDiv:   res_d = div_q;
      OpRem:   res_d = rem_r;
      OpSlt:   res_d = {63'd0, ($signed(a) < $signed(b))};
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      is_equal  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        result   <= res_d;
        is_equal <= (a == b);
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed plan vectors plus randomized ops against a reference model.
// Honours ALU_MULDIV_EN the same way as the design.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [63:0] a, b;
  logic [3:0]  op;
  logic        valid_in;
  logic [63:0] result;
  logic        is_equal;
  logic        valid_out;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .op       (op),
    .valid_in (valid_in),
    .result   (result),
    .is_equal (is_equal),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_MULDIV_EN
  localparam bit MulDiv = 1'b1;
`else
  localparam bit MulDiv = 1'b0;
`endif

  localparam logic [63:0] Msb = 64'h8000_0000_0000_0000;

  typedef struct packed {
    logic [63:0] r;
    logic        e;
    logic [3:0]  op;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] last_r  = '0;
  logic        last_e  = 1'b0;

  // Reference: rules straight from the op table, divide done on magnitudes then signed.
  function automatic logic [63:0] model(input logic [3:0] o, input logic [63:0] x,
                                        input logic [63:0] y);
    logic [63:0]         ux, uy, qm, rm;
    logic signed [127:0] px, py, p;
    logic [5:0]          sh;
    sh = y[5:0];
    ux = x[63] ? -x : x;
    uy = y[63] ? -y : y;
    if (!MulDiv && o >= 4'd7 && o <= 4'd10) return '0;
    case (o)
      4'd0: return x + y;
      4'd1: return x - y;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return x << sh;
      4'd6: return x >> sh;
      4'd7: return x * y;
      4'd8: begin
        px = $signed(x);
        py = $signed(y);
        p  = px * py;
        return p[127:64];
      end
      4'd9: begin
        if (y == '0) return '1;
        qm = ux / uy;
        return (x[63] ^ y[63]) ? -qm : qm;
      end
      4'd10: begin
        if (y == '0) return x;
        rm = ux % uy;
        return x[63] ? -rm : rm;
      end
      4'd11: return ((x ^ Msb) < (y ^ Msb)) ? 64'd1 : 64'd0;
      default: return '0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] o, input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    @(negedge clk);
    op       = o;
    a        = x;
    b        = y;
    valid_in = 1'b1;
    e.r  = model(o, x, y);
    e.e  = (x == y);
    e.op = o;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    valid_in = 1'b0;
    a        = $urandom();
    b        = $urandom();
    op       = 4'($urandom_range(0, 15));
  endtask

  task automatic check_reset(input string tag);
    n_tests++;
    if (result !== '0 || is_equal !== 1'b0 || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: result=%h is_equal=%b valid_out=%b, want all zero",
               tag, result, is_equal, valid_out);
    end
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return Msb;
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  // Monitor: pops one expectation per valid output, checks hold otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        n_tests++;
        if (valid_out === 1'b1) begin
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_valid: valid_out=1 with no operation pending");
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (result !== e.r || is_equal !== e.e) begin
              n_fail++;
              $display("FAIL op%0d: result=%h is_equal=%b, want result=%h is_equal=%b",
                       e.op, result, is_equal, e.r, e.e);
            end
            last_r = e.r;
            last_e = e.e;
          end
        end else if (sb_q.size() != 0) begin
          n_fail++;
          $display("FAIL missing_valid: valid_out=%b with operation pending", valid_out);
          void'(sb_q.pop_front());
        end else if (result !== last_r || is_equal !== last_e) begin
          n_fail++;
          $display("FAIL hold: result=%h is_equal=%b, want held %h %b",
                   result, is_equal, last_r, last_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    op       = '0;
    #12;
    check_reset("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'd0, 64'd5, 64'd5);
    issue(4'd1, 64'd66, 64'd11);
    issue(4'd2, 64'd5, 64'd6);
    issue(4'd3, 64'd5, 64'd6);
    issue(4'd4, 64'd6, 64'd2);
    issue(4'd5, 64'd1, 64'd3);
    issue(4'd6, 64'd8, 64'd2);
    issue(4'd11, 64'd1, 64'd9);
    issue(4'd11, '1, 64'd0);
    issue(4'd11, 64'd9, 64'd1);
    issue(4'd1, 64'd42, 64'd42);
    issue(4'd0, 64'd42, 64'd43);
    issue(4'd7, 64'd6, 64'd5);
    issue(4'd15, 64'd3, 64'd4);
`ifdef ALU_MULDIV_EN
    issue(4'd8, 64'd5, 64'd3);
    issue(4'd8, '1, 64'd1);
    issue(4'd9, 64'd66, 64'd11);
    issue(4'd10, 64'd62, 64'd3);
    issue(4'd9, 64'd123, 64'd0);
    issue(4'd10, 64'd7, 64'd0);
    issue(4'd9, Msb, '1);
    issue(4'd10, Msb, '1);
`endif
    issue(4'd0, 64'd100, 64'd23);
    idle();
    idle();
    idle();

    // Reset mid-operation: pending op is dropped, outputs clear before any edge.
    issue(4'd3, 64'hf0, 64'h0f);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    sb_q.delete();
    last_r = '0;
    last_e = 1'b0;
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        logic [63:0] x, y;
        x = rnd_operand();
        y = ($urandom_range(0, 7) == 0) ? x : rnd_operand();
        issue(4'($urandom_range(0, 15)), x, y);
      end
    end
    idle();
    idle();
    idle();

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d operations never produced output, want 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
